// File: rtl/opcode_fetch.sv
// opcode_fetch: steps a fixed opcode table one entry per trigger, valid/ack out.
// Define OPCODE_FETCH_LOOP_EN to wrap after the last entry instead of DONE.
module opcode_fetch #(
  parameter int MAX_ADDR = 3,
  parameter int OP_W     = 8,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              trigger,
  input  logic              ack,
  output logic [OP_W-1:0]   opcode,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_FETCH,
    S_PRESENT,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [OP_W-1:0]   opcode_q, opcode_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;
  logic              last;

  // Entry k is 0xA0 with the low nibble of k, resized to OP_W.
  function automatic logic [OP_W-1:0] table_entry(
    input logic [ADDR_W-1:0] a
  );
    logic [7:0] e;
    e = 8'hA0 | (8'(a) & 8'h0F);
    return OP_W'(e);
  endfunction

  assign last = (addr_q == ADDR_W'(MAX_ADDR));

  // Next-state and datapath update; load overrides everything else.
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    valid_d   = valid_q;
    addr_d    = addr_q;
    overrun_d = overrun_q;
    if (load) begin
      state_d   = S_ARMED;
      addr_d    = '0;
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end else begin
      if (trigger && state_q != S_ARMED) begin
        overrun_d = 1'b1;
      end
      unique case (state_q)
        S_IDLE: begin
        end
        S_ARMED: begin
          if (trigger) begin
            state_d = S_FETCH;
          end
        end
        S_FETCH: begin
          opcode_d = table_entry(addr_q);
          valid_d  = 1'b1;
          state_d  = S_PRESENT;
        end
        S_PRESENT: begin
          if (ack && valid_q) begin
            valid_d = 1'b0;
            if (last) begin
`ifdef OPCODE_FETCH_LOOP_EN
              addr_d  = '0;
              state_d = S_ARMED;
`else
              state_d = S_DONE;
`endif
            end else begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = S_ARMED;
            end
          end
        end
        S_DONE: begin
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Status flags are decoded from the next state so they stay registered.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (1'b1)
      (state_d == S_ARMED),
      (state_d == S_FETCH),
      (state_d == S_PRESENT): busy_d = 1'b1;
      (state_d == S_DONE):    done_d = 1'b1;
      default: begin
      end
    endcase
  end

  // State and output registers; reset drops valid immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      opcode_q  <= '0;
      valid_q   <= 1'b0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign opcode  = opcode_q;
  assign valid   = valid_q;
  assign addr    = addr_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_opcode_fetch.sv
// tb_opcode_fetch: directed plan plus random load/trigger/ack/reset traffic,
// checked every cycle against a sequence-level reference model.
module tb_opcode_fetch;

  localparam int MAX_ADDR = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic       trigger = 1'b0;
  logic       ack = 1'b0;
  logic [7:0] opcode;
  logic       valid;
  logic [7:0] addr;
  logic       busy;
  logic       done;
  logic       overrun;

  int n_checks = 0;
  int n_pass   = 0;

  bit       m_armed, m_fetch, m_valid, m_done, m_over;
  int       m_addr;
  bit [7:0] m_op;

  opcode_fetch #(
    .MAX_ADDR(MAX_ADDR),
    .OP_W(8),
    .ADDR_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .trigger(trigger),
    .ack(ack),
    .opcode(opcode),
    .valid(valid),
    .addr(addr),
    .busy(busy),
    .done(done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp,
               $time);
    else
      n_pass++;
  endtask

  task automatic model_reset();
    m_armed = 0; m_fetch = 0; m_valid = 0; m_done = 0; m_over = 0;
    m_addr = 0; m_op = 8'h00;
  endtask

  // One clock of the sequence: where are we in the walk of the table.
  task automatic model_step(input bit l, input bit t, input bit a);
    if (l) begin
      m_armed = 1; m_fetch = 0; m_valid = 0; m_done = 0;
      m_addr = 0; m_over = 0;
    end else begin
      if (t && !m_armed) m_over = 1;
      if (m_armed) begin
        if (t) begin
          m_armed = 0;
          m_fetch = 1;
        end
      end else if (m_fetch) begin
        m_fetch = 0;
        m_valid = 1;
        m_op = 8'hA0 + 8'(m_addr % 16);
      end else if (m_valid && a) begin
        m_valid = 0;
        if (m_addr == MAX_ADDR) begin
`ifdef OPCODE_FETCH_LOOP_EN
          m_addr = 0;
          m_armed = 1;
`else
          m_done = 1;
`endif
        end else begin
          m_addr = m_addr + 1;
          m_armed = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("opcode", 32'(opcode), 32'(m_op));
    check("valid", 32'(valid), 32'(m_valid));
    check("addr", 32'(addr), 32'(m_addr));
    check("busy", 32'(busy), 32'(m_armed | m_fetch | m_valid));
    check("done", 32'(done), 32'(m_done));
    check("overrun", 32'(overrun), 32'(m_over));
  endtask

  // Drive strobes at the falling edge, advance one clock, check at the next.
  task automatic tick(input bit l, input bit t, input bit a);
    load = l; trigger = t; ack = a;
    @(posedge clk);
    model_step(l, t, a);
    @(negedge clk);
    load = 0; trigger = 0; ack = 0;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0);
  endtask

  // Asynchronous reset applied between edges, released at a falling edge.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    rst = 1'b1;
  endtask

  // Trigger, wait for the opcode to appear, then ack after a delay.
  task automatic one_entry(input int ack_delay);
    tick(0, 1, 0);
    idle(2);
    idle(ack_delay);
    tick(0, 0, 1);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    tick(1, 0, 0);
    for (int k = 0; k <= MAX_ADDR; k++) one_entry(2);
`ifndef OPCODE_FETCH_LOOP_EN
    check("seq_end_done", 32'(done), 32'd1);
    check("seq_end_addr", 32'(addr), 32'(MAX_ADDR));
`else
    one_entry(0);
    check("wrap_opcode", 32'(opcode), 32'hA0);
`endif
    tick(0, 1, 0);
    idle(2);

    tick(1, 0, 0);
    tick(0, 1, 0);
    idle(2);
    tick(0, 1, 0);
    check("present_overrun", 32'(overrun), 32'd1);
    tick(1, 0, 0);

    one_entry(0);
    one_entry(1);
    tick(1, 1, 0);
    tick(0, 1, 0);
    idle(2);
    check("reload_opcode", 32'(opcode), 32'hA0);
    tick(0, 0, 1);

    tick(0, 1, 0);
    idle(2);
    do_reset();
    tick(0, 1, 0);
    idle(1);

    tick(1, 0, 0);
    tick(0, 0, 1);
    tick(0, 0, 1);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(999) < 4) begin
        do_reset();
      end else begin
        tick($urandom_range(99) < 2, $urandom_range(99) < 30,
             $urandom_range(99) < 40);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
